// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
//   Multicycle MULT/MULTU/DIV/DIVU engine and sole writer of the HI/LO pair.
//   A shift-add multiplier or a restoring divider retires one bit per cycle.
//   A one-cycle sign fix-up follows, then a one-cycle write.
//   MTHI/MTLO are passed straight through while the engine is idle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO honoured when start is low
//   CALC  | WIDTH iterations of multiply or divide
//   FIX   | two's-complement sign correction, result registered
//   WRITE | done pulse; HI/LO written unless the divisor was zero
//
// Ports
//   clk, reset           clock, async active-low reset
//   start, op, a, b      operation request (op: 00 MULT 01 MULTU 10 DIV 11 DIVU)
//   mt_hi, mt_lo,
//   mt_data              MTHI/MTLO requests and data
//   busy, done,
//   div_by_zero          status to the main control FSM
//   hi_in, lo_in,
//   hi_write, lo_write   HI/LO write data and enables
module mult_div_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi_in,
   output logic [WIDTH-1:0] lo_in,
   output logic             hi_write,
   output logic             lo_write
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WRITE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;
   logic             r_sign_a;
   logic             r_sign_b;
   logic [WIDTH-1:0] r_x;       // multiplicand, or divisor
   logic [WIDTH-1:0] r_hi;      // product high half, or partial remainder
   logic [WIDTH-1:0] r_lo;      // multiplier/product low half, or dividend/quotient
   logic [WIDTH-1:0] r_hi_out;
   logic [WIDTH-1:0] r_lo_out;
   logic             r_hi_wr;
   logic             r_lo_wr;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;

   logic             w_signed;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_msum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_hi_fix;
   logic [WIDTH-1:0] w_lo_fix;
   logic             w_mt_ok;
   logic             w_mt_hi;
   logic             w_mt_lo;

   always_comb begin
      w_signed = ~op[0];
      w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
      w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

      // Multiply: add multiplicand into the high half when the low bit is set,
      // then shift the whole {carry, hi, lo} right by one.
      w_msum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_x : '0)};

      // Divide: the remainder stays below the divisor, so one extra bit holds
      // the shifted value and the borrow of the trial subtraction.
      w_shift  = {r_hi, r_lo[WIDTH-1]};
      w_trial  = w_shift - {1'b0, r_x};

      w_hi_nxt = '0;
      w_lo_nxt = '0;
      if (r_is_div) begin
         if (!w_trial[WIDTH]) begin
            w_hi_nxt = w_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_hi_nxt = w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_hi_nxt = w_msum[WIDTH:1];
         w_lo_nxt = {w_msum[0], r_lo[WIDTH-1:1]};
      end

      // Sign flags are only captured for signed ops, so no op check needed.
      w_prod   = {r_hi, r_lo};
      w_hi_fix = r_hi;
      w_lo_fix = r_lo;
      if (r_is_div) begin
         if (r_sign_a ^ r_sign_b) w_lo_fix = -r_lo;
         if (r_sign_a)            w_hi_fix = -r_hi;
      end else if (r_sign_a ^ r_sign_b) begin
         w_prod   = -w_prod;
         w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
         w_lo_fix = w_prod[WIDTH-1:0];
      end

      w_mt_ok  = reset && (r_state == S_IDLE) && !start;
      w_mt_hi  = w_mt_ok && mt_hi;
      w_mt_lo  = w_mt_ok && mt_lo;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_x      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_hi_out <= '0;
         r_lo_out <= '0;
         r_hi_wr  <= 1'b0;
         r_lo_wr  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi_wr <= 1'b0;
         r_lo_wr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_div <= op[1];
                  r_sign_a <= w_signed & a[WIDTH-1];
                  r_sign_b <= w_signed & b[WIDTH-1];
                  r_cnt    <= '0;
                  r_hi     <= '0;
                  if (op[1] && (b == '0)) begin
                     r_state <= S_WRITE;
                     r_done  <= 1'b1;
                     r_dbz   <= 1'b1;
                  end else begin
                     r_state <= S_CALC;
                     r_busy  <= 1'b1;
                     r_lo    <= op[1] ? w_abs_a : w_abs_b;
                     r_x     <= op[1] ? w_abs_b : w_abs_a;
                  end
               end else begin
                  // Keep MT data as the held output value after the write.
                  if (mt_hi) r_hi_out <= mt_data;
                  if (mt_lo) r_lo_out <= mt_data;
               end
            end
            S_CALC: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) r_state <= S_FIX;
            end
            S_FIX: begin
               r_hi_out <= w_hi_fix;
               r_lo_out <= w_lo_fix;
               r_hi_wr  <= 1'b1;
               r_lo_wr  <= 1'b1;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_WRITE;
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi_in       = w_mt_hi ? mt_data : r_hi_out;
   assign lo_in       = w_mt_lo ? mt_data : r_lo_out;
   assign hi_write    = r_hi_wr | w_mt_hi;
   assign lo_write    = r_lo_wr | w_mt_lo;

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Multicycle controller for the MULT/MULTU/DIV/DIVU instructions and for MTHI/MTLO, and the only writer of the HI/LO register pair.
- Accepts one operation from the main control unit and runs an iterative shift-add multiplier or restoring divider, one bit per cycle.
- Drives the HI/LO register write data and write enables.
- Signals busy/done so the control FSM can stall MFHI/MFLO until the result is committed.

Parameters:
WIDTH, 32, operand width and HI/LO register width.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
start  input  1  one-cycle request to begin the operation selected by op.
op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
a  input  WIDTH  rs operand; the dividend for DIV/DIVU.
b  input  WIDTH  rt operand; the divisor for DIV/DIVU.
mt_hi  input  1  MTHI request; writes mt_data into HI.
mt_lo  input  1  MTLO request; writes mt_data into LO.
mt_data  input  WIDTH  data for MTHI/MTLO.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle completion pulse.
div_by_zero  output  1  one-cycle flag, asserted together with done.
hi_in  output  WIDTH  write data to the HI register.
lo_in  output  WIDTH  write data to the LO register.
hi_write  output  1  HI write enable.
lo_write  output  1  LO write enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - state returns to IDLE.
  - busy, done, div_by_zero, hi_write, lo_write, hi_in and lo_in are all 0.
  - Any operation in progress is abandoned; no write is issued.
- States: IDLE, CALC, FIX, WRITE.
- IDLE:
  - start=1 captures op, |a| and |b|, and the operand signs (signs only for MULT/DIV).
  - The iteration counter is cleared. Next state is CALC, and busy=1 from the next cycle.
  - Exception: DIV/DIVU with b==0 goes straight to WRITE and sets a pending div_by_zero flag.
- CALC:
  - Exactly WIDTH cycles; the counter runs 0..WIDTH-1, then the FSM moves to FIX.
  - Multiply: 64-bit accumulator. Each cycle, add the shifted multiplicand if the current multiplier bit is 1, then shift.
  - Divide: restoring algorithm. Each cycle, shift the remainder left and bring in the next dividend bit. Subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore the remainder.
- FIX (1 cycle): sign correction, two's complement, applied only for signed ops.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. Division truncates toward zero and the remainder takes the sign of the dividend.
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000. No trap is raised.
  - Output mapping: multiply gives hi_in = product[63:32], lo_in = product[31:0]. Divide gives lo_in = quotient, hi_in = remainder.
- WRITE (1 cycle):
  - Normal completion: done=1 and hi_write=lo_write=1 for this single cycle. HI/LO update on the edge that ends WRITE.
  - Divide by zero: done=1, div_by_zero=1, hi_write=lo_write=0, so HI/LO keep their previous values.
  - busy falls when WRITE is entered. Next state is IDLE.
- Latency, with the start-sampling edge as edge 0:
  - Normal operation: done is high during the cycle after edge WIDTH+1, i.e. edge 33 for WIDTH=32. HI/LO are valid after edge 34.
  - Divide by zero: done is high in the cycle after edge 0.
- MTHI/MTLO:
  - Honoured only in IDLE with start=0.
  - Output is combinational in that same cycle: hi_in/lo_in = mt_data, with hi_write=mt_hi and lo_write=mt_lo.
  - done is not asserted for MTHI/MTLO.
- Simultaneous and illegal requests:
  - start together with mt_hi/mt_lo in IDLE: start wins and the MT request is dropped.
  - start while busy: ignored. The operands of the running operation are not disturbed.
  - mt_hi/mt_lo while busy or in WRITE: ignored, with no write.
- Output hold: hi_in and lo_in keep their last driven value whenever the write enables are 0.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles; done, hi_write and lo_write high together in one cycle; hi_in=0xFFFFFFFE, lo_in=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi_in=0xFFFFFFFF, lo_in=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 -> lo_in=0xFFFFFFFD, hi_in=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo_in=0x80000000, hi_in=0; DIVU a=100, b=7 -> lo_in=14, hi_in=2.
- DIVU a=5, b=0 -> done=1 and div_by_zero=1 one cycle after start; hi_write=lo_write=0; busy is never high for more than one cycle.
- MTHI mt_data=0x12345678 in IDLE -> hi_write=1, lo_write=0, hi_in=0x12345678 in the same cycle. mt_lo and a second start pulsed during CALC -> no write; the running result is unchanged.
- Drive reset=0 at cycle 10 of a MULT -> all outputs 0 immediately and no done/write follows. After release, a new MULTU 3*4 -> lo_in=12, hi_in=0.
